// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: two-requester round-robin packet arbiter driving a 2:1 beat mux
module mux_rr_arbiter #(
    parameter int WIDTH     = 16,
    parameter int MAX_BEATS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_a,
    input  logic             valid_b,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic             last_a,
    input  logic             last_b,
    output logic             ready_a,
    output logic             ready_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             sel,
    output logic             grant_a,
    output logic             grant_b
);
    typedef enum logic [1:0] {IDLE = 2'd0, GNT_A = 2'd1, GNT_B = 2'd2} state_t;
    localparam logic [7:0] LAST_BEAT = 8'(MAX_BEATS - 1);
    state_t     r_state;
    logic       r_prio;
    logic       r_sel;
    logic [7:0] r_cnt;
    logic       w_gnt_a;
    logic       w_gnt_b;
    logic       w_valid;
    logic       w_last;
    logic       w_xfer;
    logic       w_rel;
    assign w_gnt_a   = r_state == GNT_A;
    assign w_gnt_b   = r_state == GNT_B;
    assign w_valid   = w_gnt_a ? valid_a : w_gnt_b ? valid_b : 1'b0;
    assign w_last    = w_gnt_a ? last_a : w_gnt_b ? last_b : 1'b0;
    // reset suppresses the handshake so an aborted beat is never seen as accepted
    assign w_xfer    = w_valid & out_ready & ~rst;
    assign w_rel     = w_xfer & (w_last | (r_cnt == LAST_BEAT));
    assign out_valid = w_valid & ~rst;
    assign out_data  = w_gnt_a ? data_a : w_gnt_b ? data_b : '0;
    assign out_last  = w_last;
    assign ready_a   = w_gnt_a & out_ready & ~rst;
    assign ready_b   = w_gnt_b & out_ready & ~rst;
    assign sel       = r_sel;
    assign grant_a   = w_gnt_a;
    assign grant_b   = w_gnt_b;
    // arbitration FSM: grant from IDLE by priority, count beats, release back through IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_prio  <= 1'b0;
            r_cnt   <= 8'd0;
            r_sel   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid_a && (!valid_b || !r_prio)) begin
                        r_state <= GNT_A;
                        r_sel   <= 1'b0;
                    end else if (valid_b) begin
                        r_state <= GNT_B;
                        r_sel   <= 1'b1;
                    end
                end
                GNT_A, GNT_B: begin
                    if (w_rel) begin
                        r_state <= IDLE;
                        r_cnt   <= 8'd0;
                        r_prio  <= w_gnt_a;
                    end else if (w_xfer) begin
                        r_cnt   <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed vectors checked against a packet-level arbitration model
module tb_mux_rr_arbiter;
    localparam int WIDTH     = 16;
    localparam int MAX_BEATS = 8;
    logic             clk;
    logic             rst;
    logic             valid_a;
    logic             valid_b;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic             last_a;
    logic             last_b;
    logic             ready_a;
    logic             ready_b;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_ready;
    logic             sel;
    logic             grant_a;
    logic             grant_b;
    int n_vec  = 0;
    int n_miss = 0;
    mux_rr_arbiter #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
        .clk(clk), .rst(rst),
        .valid_a(valid_a), .valid_b(valid_b),
        .data_a(data_a), .data_b(data_b),
        .last_a(last_a), .last_b(last_b),
        .ready_a(ready_a), .ready_b(ready_b),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .sel(sel),
        .grant_a(grant_a), .grant_b(grant_b)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // model: owner is -1 when nobody holds the bus, else 0 (A) or 1 (B)
    bit armed   = 1'b0;
    int m_own   = -1;
    bit m_prio  = 1'b0;
    int m_beats = 0;
    bit m_sel   = 1'b0;
    always @(posedge clk) begin
        if (rst) begin
            armed   <= 1'b1;
            m_own   <= -1;
            m_prio  <= 1'b0;
            m_beats <= 0;
            m_sel   <= 1'b0;
        end else if (m_own < 0) begin
            if (valid_a || valid_b) begin
                m_own <= (valid_a && valid_b) ? (m_prio ? 1 : 0) : (valid_b ? 1 : 0);
                m_sel <= (valid_a && valid_b) ? m_prio : valid_b;
            end
        end else if ((m_own == 0 ? valid_a : valid_b) && out_ready) begin
            if ((m_own == 0 ? last_a : last_b) || m_beats + 1 == MAX_BEATS) begin
                m_own   <= -1;
                m_beats <= 0;
                m_prio  <= (m_own == 0);
            end else begin
                m_beats <= m_beats + 1;
            end
        end
    end
    // every cycle: outputs must match what the model says the owner presents
    always @(negedge clk) begin
        if (armed) begin
            chk("grant_a", 32'(grant_a), 32'(m_own == 0));
            chk("grant_b", 32'(grant_b), 32'(m_own == 1));
            chk("sel", 32'(sel), 32'(m_sel));
            chk("out_valid", 32'(out_valid), 32'(!rst && (m_own == 0 ? valid_a : m_own == 1 ? valid_b : 1'b0)));
            chk("out_data", 32'(out_data), 32'(m_own == 0 ? data_a : m_own == 1 ? data_b : 16'h0));
            chk("out_last", 32'(out_last), 32'(m_own == 0 ? last_a : m_own == 1 ? last_b : 1'b0));
            chk("ready_a", 32'(ready_a), 32'(!rst && m_own == 0 && out_ready));
            chk("ready_b", 32'(ready_b), 32'(!rst && m_own == 1 && out_ready));
            chk("ready_excl", 32'(ready_a & ready_b), 32'(0));
            chk("grant_excl", 32'(grant_a & grant_b), 32'(0));
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic va, input logic [15:0] da, input logic la,
                         input logic vb, input logic [15:0] db, input logic lb, input logic ordy);
        valid_a = va; data_a = da; last_a = la;
        valid_b = vb; data_b = db; last_b = lb;
        out_ready = ordy;
    endtask
    bit exp_ga [8]  = '{0, 1, 0, 0, 0, 1, 0, 0};
    bit exp_gb [8]  = '{0, 0, 0, 1, 0, 0, 0, 1};
    bit exp_sel [8] = '{0, 0, 0, 1, 1, 0, 0, 1};
    int a_sent;
    int n_a;
    int n_b;
    initial begin
        rst = 1'b1;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_grant_a", 32'(grant_a), 32'(0));
        chk("rst_grant_b", 32'(grant_b), 32'(0));
        chk("rst_sel", 32'(sel), 32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_ready", 32'({ready_a, ready_b}), 32'(0));
        // both requesting single-beat packets: A,B alternate with an IDLE gap
        tick();
        drive(1'b1, 16'h00A1, 1'b1, 1'b1, 16'h00B1, 1'b1, 1'b1);
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("alt_grant_a", 32'(grant_a), 32'(exp_ga[i]));
            chk("alt_grant_b", 32'(grant_b), 32'(exp_gb[i]));
            chk("alt_sel", 32'(sel), 32'(exp_sel[i]));
            tick();
            #1;
        end
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        // B alone, three-beat packet
        tick();
        drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h0011, 1'b0, 1'b1);
        #1;
        chk("b3_idle", 32'(grant_b), 32'(0));
        tick();
        #1;
        chk("b3_grant", 32'(grant_b), 32'(1));
        chk("b3_d1", 32'(out_data), 32'h0011);
        chk("b3_ready", 32'(ready_b), 32'(1));
        tick();
        data_b = 16'h0022;
        #1;
        chk("b3_d2", 32'(out_data), 32'h0022);
        tick();
        data_b = 16'h0033;
        last_b = 1'b1;
        #1;
        chk("b3_d3", 32'(out_data), 32'h0033);
        chk("b3_last", 32'(out_last), 32'(1));
        tick();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        #1;
        chk("b3_release", 32'(grant_b), 32'(0));
        chk("b3_sel_hold", 32'(sel), 32'(1));
        // A streams without last while B waits: forced release after MAX_BEATS
        tick();
        a_sent = 0;
        n_a = 0;
        drive(1'b1, 16'h0100, 1'b0, 1'b1, 16'hBEEF, 1'b1, 1'b1);
        #1;
        for (int i = 0; i < 12; i++) begin
            if (grant_a) n_a++;
            if (ready_a && valid_a) a_sent++;
            if (i == 9) chk("force_idle", 32'({grant_a, grant_b}), 32'(0));
            if (i == 10) chk("force_then_b", 32'(grant_b), 32'(1));
            tick();
            if (i == 10) valid_b = 1'b0;
            data_a = 16'h0100 + 16'(a_sent);
            #1;
        end
        chk("force_a_beats", 32'(n_a), 32'(8));
        chk("force_regrant_a", 32'(grant_a), 32'(1));
        // six more beats, then stall five cycles, then two beats to the forced release
        for (int i = 0; i < 6; i++) begin
            if (ready_a && valid_a) a_sent++;
            tick();
            data_a = 16'h0100 + 16'(a_sent);
            #1;
        end
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_ready_a", 32'(ready_a), 32'(0));
            chk("stall_grant_a", 32'(grant_a), 32'(1));
            chk("stall_data", 32'(out_data), 32'h0100 + 32'(a_sent));
            tick();
            #1;
        end
        out_ready = 1'b1;
        #1;
        chk("stall_resume", 32'(ready_a), 32'(1));
        a_sent++;
        tick();
        data_a = 16'h0100 + 16'(a_sent);
        #1;
        chk("stall_beat8", 32'(grant_a), 32'(1));
        tick();
        valid_a = 1'b0;
        #1;
        chk("stall_release", 32'(grant_a), 32'(0));
        // reset in the middle of a B grant
        drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h0B0B, 1'b0, 1'b1);
        tick();
        #1;
        chk("rb_grant", 32'(grant_b), 32'(1));
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rb_no_ready", 32'(ready_b), 32'(0));
        chk("rb_no_valid", 32'(out_valid), 32'(0));
        tick();
        rst = 1'b0;
        valid_b = 1'b0;
        #1;
        chk("rb_grant_b", 32'(grant_b), 32'(0));
        chk("rb_sel", 32'(sel), 32'(0));
        chk("rb_out_valid", 32'(out_valid), 32'(0));
        tick();
        valid_b = 1'b1;
        #1;
        n_b = 0;
        for (int i = 0; i < 10; i++) begin
            if (grant_b) n_b++;
            tick();
            #1;
        end
        chk("rb_cnt_cleared", 32'(n_b), 32'(8));
        valid_b = 1'b0;
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data width of each requester and the output.
REQ-002 SHALL have parameter MAX_BEATS, default 8: beats per grant before forced release; legal range 1..255.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-005 SHALL have ports valid_a and valid_b, input, 1 each: requester A/B has a beat pending.
REQ-006 SHALL have ports data_a and data_b, input, WIDTH each: requester A/B beat data.
REQ-007 SHALL have ports last_a and last_b, input, 1 each: the current beat ends the requester's packet.
REQ-008 SHALL have ports ready_a and ready_b, output, 1 each: requester A/B beat accepted this cycle when its valid is also high.
REQ-009 SHALL have port out_valid, output, 1: a beat is presented downstream.
REQ-010 SHALL have port out_data, output, WIDTH: the granted requester's data.
REQ-011 SHALL have port out_last, output, 1: the granted requester's last.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts the beat.
REQ-013 SHALL have port sel, output, 1: 2:1 mux select, 0 = A and 1 = B.
REQ-014 SHALL have ports grant_a and grant_b, output, 1 each: registered one-hot grant; both low in IDLE.

Function
REQ-015 SHALL implement a registered FSM with states IDLE, GNT_A and GNT_B.
REQ-016 IDLE: SHALL drive out_valid=0, ready_a=0 and ready_b=0.
REQ-017 IDLE, only valid_a high -> next state GNT_A.
REQ-018 IDLE, only valid_b high -> next state GNT_B.
REQ-019 IDLE, both valid high -> SHALL grant the requester named by the priority pointer prio (0 = A, 1 = B).
REQ-020 IDLE, neither valid high -> SHALL stay in IDLE.
REQ-021 Grant latency SHALL be exactly 1 cycle: valid sampled in IDLE, grant active the following cycle.
REQ-022 GNT_X: out_valid = valid_X, out_data = data_X, out_last = last_X, ready_X = out_ready; the other ready SHALL be 0 (combinational pass-through).
REQ-023 A transfer is the condition valid_X && out_ready while in GNT_X; beat_cnt (8-bit) SHALL increment on each transfer.
REQ-024 Release SHALL occur on a transfer with last_X=1, or on a transfer when beat_cnt == MAX_BEATS-1.
REQ-025 On release: next state IDLE, beat_cnt cleared to 0, prio set to the other requester.
REQ-026 Every grant SHALL be followed by one mandatory IDLE cycle after release.
REQ-027 In GNT_X, valid_X low SHALL NOT release the grant; the grant holds indefinitely until release.
REQ-028 A waiting requester's data SHALL NOT reach out_data while it is not granted.
REQ-029 sel SHALL be registered: 1 in GNT_B; holds its last value in IDLE (glitch-free for the downstream mux).
REQ-030 grant_a/grant_b SHALL decode state directly; never both high.
REQ-031 A forced release (MAX_BEATS reached) with the packet unfinished: the requester re-arbitrates normally; no data SHALL be dropped or duplicated.

Reset
REQ-032 rst=1 at a clock edge SHALL set state=IDLE, prio=0 (A), beat_cnt=0, sel=0; outputs then read grant_a=0, grant_b=0, out_valid=0, ready_a=0, ready_b=0.
REQ-033 rst asserted mid-grant SHALL abort the transfer with no handshake completed in that cycle; the requester must resend after reset.
REQ-034 rst SHALL have priority over all other inputs.

Verification
REQ-035 After reset, valid_a=valid_b=1 with 1-beat packets (last=1), out_ready=1: grants SHALL alternate A,B,A,B with sel 0,1,0,1 and one IDLE cycle between grants.
REQ-036 Only valid_b=1 with a 3-beat packet (data 0x0011, 0x0022, 0x0033, last on the 3rd beat): GNT_B for 3 cycles, out_data in that order, then IDLE and prio=0.
REQ-037 MAX_BEATS=8, A streams 12 beats with no last while valid_b=1: A granted for 8 transfers, then IDLE, then GNT_B.
REQ-038 GNT_A with out_ready=0 for 5 cycles: ready_a=0, out_data stable = data_a, beat_cnt unchanged, no release.
REQ-039 rst=1 in GNT_B after 2 beats: next cycle state=IDLE, sel=0, grant_b=0 and beat_cnt=0.
REQ-040 Bench SHALL check throughout: at most one of ready_a/ready_b high, and grant_a/grant_b mutually exclusive.
